pipeline_hazard_controller: RTL and testbench
=============================================

Name: pipeline_hazard_controller

Overview:
- Central sequencer for the 5-stage MIPS pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC register.
- Generates per-stage enable/clear, PC-source select and EPC-load strobes each cycle.
- Stalls on load-use, flushes on branch/jump/eret, freezes on halt, and drains the pipe before vectoring to an interrupt.
- Sits beside the ID/EX decode logic; all pipeline registers take their enable/clear directly from this block.

Parameters:
- DRAIN_CYCLES, 3, bubble cycles injected before the interrupt vector (must be ≥1, ≤15).
- REG_ADDR_W, 5, register-number width.

Ports:
- clock  in  1  system clock, rising edge
- resetN  in  1  asynchronous active-low reset
- idRs, idRt  in  REG_ADDR_W  source registers of instruction in ID
- idUsesRs, idUsesRt  in  1  ID instruction actually reads rs / rt
- idJump  in  1  j/jal/jr/jalr decoded in ID
- idEret  in  1  eret decoded in ID
- exMemRead  in  1  instruction in EX is a load
- exRegWrite  in  1  instruction in EX writes a register
- exRd  in  REG_ADDR_W  destination register of EX instruction
- exBranchTaken  in  1  branch in EX resolved taken
- exHalt  in  1  halt syscall in EX
- resume  in  1  leave HALT (level, sampled at clock)
- irq  in  1  external interrupt request (level)
- intEnable  in  1  interrupt-enable bit from status register
- pcEnable, ifidEnable, idexEnable, exmemEnable, memwbEnable  out  1 each  register enables
- ifidClear, idexClear, exmemClear, memwbClear  out  1 each  synchronous clears (effective only with enable=1)
- pcSelect  out  3  next-PC source
- epcLoad  out  1  capture current PC into EPC
- intAck  out  1  one-cycle acknowledge to interrupt controller
- halted  out  1  controller in HALT

Behaviour:
- States: RUN, DRAIN, VECTOR, HALT; 4-bit drain counter. Outputs are combinational from state and inputs; state/counter are registered.
- Reset (resetN=0, async): state=RUN, counter=0. While asserted: all enables=1, all clears=1, pcSelect=SEQ, epcLoad=intAck=halted=0. Reset mid-DRAIN/HALT aborts to RUN with no intAck.
- Default in RUN: all enables=1, all clears=0, pcSelect=SEQ.
- loadUse = exMemRead & exRegWrite & exRd≠0 & ((idUsesRs & exRd==idRs) | (idUsesRt & exRd==idRt)).
- RUN priority, highest first:
  1. exHalt → next HALT. This cycle: pcEnable=0, ifidEnable=0, idexClear=1.
  2. exBranchTaken → pcSelect=BRANCH, ifidClear=1, idexClear=1. Any loadUse/jump/irq is ignored this cycle.
  3. loadUse → pcEnable=0, ifidEnable=0, idexClear=1 (one bubble). idJump/idEret are suppressed; irq is deferred.
  4. irq & intEnable → epcLoad=1, pcEnable=0, ifidClear=1, counter=DRAIN_CYCLES−1, next DRAIN.
  5. idEret → pcSelect=EPC, ifidClear=1.
  6. idJump → pcSelect=JUMP, ifidClear=1.
- DRAIN: pcEnable=0, ifidClear=1, EX/MEM/WB enabled normally. Counter decrements each cycle; at 0 → VECTOR.
  - exHalt during DRAIN still takes priority: → HALT, the interrupt is dropped and no intAck is issued.
  - exBranchTaken during DRAIN: idexClear=1 only; PC stays held (EPC already captured).
- VECTOR (exactly 1 cycle): pcSelect=VECTOR, pcEnable=1, ifidClear=1, intAck=1 → RUN.
- HALT: pcEnable=0, ifidEnable=0, idexEnable=0, exmemEnable=1, memwbEnable=1, exmemClear=1 (older instructions retire; no new ones enter), halted=1. resume=1 → RUN next cycle. irq is ignored in HALT.
- Latency: every stall/flush decision takes effect at the same clock edge it is evaluated for. HALT, DRAIN and VECTOR entry take effect on the next edge.

Decomposition:
- Package pipeline_ctrl_pkg: state enum (RUN=0, DRAIN=1, VECTOR=2, HALT=3); pcSelect codes (SEQ=0, BRANCH=1, JUMP=2, EPC=3, VECTOR=4); REG_ADDR_W default.
- Sub-module hazard_detect: combinational loadUse comparator. Keeping it separate lets forwarding logic reuse it.

Test Plan:
- Load-use: EX lw to $8 (exMemRead=1, exRegWrite=1, exRd=8), ID add uses rs=8 → pcEnable=0, ifidEnable=0, idexClear=1 for exactly 1 cycle. The same case with exRd=0 → no stall.
- Branch beats load-use and jump: exBranchTaken=1, loadUse=1, idJump=1 in the same cycle → pcSelect=1, ifidClear=1, idexClear=1, pcEnable=1.
- Interrupt with DRAIN_CYCLES=3, irq=intEnable=1 in RUN → epcLoad pulse at cycle 0, 3 cycles with pcEnable=0, then 1 VECTOR cycle with pcSelect=4 and intAck=1, then RUN.
- Halt then resume: exHalt=1 → halted=1 from the next cycle, pcEnable/ifidEnable/idexEnable=0 held for 10 cycles, irq ignored; resume=1 → RUN next cycle, halted=0.
- Reset mid-DRAIN: assert resetN=0 at DRAIN cycle 1 → state RUN immediately (async), all clears=1; on release, no intAck and pcSelect=0.
- Eret vs jump: idEret=1 and idJump=1 together → pcSelect=3, ifidClear=1. During a loadUse stall, both are suppressed (pcSelect=0).

Source files
------------

// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and encodings for the pipeline hazard controller.
package pipeline_ctrl_pkg;

  localparam int REG_ADDR_W_DEF = 5;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_VECTOR = 2'd2,
    ST_HALT   = 2'd3
  } ctrl_state_e;

  localparam logic [2:0] PC_SEQ    = 3'd0;
  localparam logic [2:0] PC_BRANCH = 3'd1;
  localparam logic [2:0] PC_JUMP   = 3'd2;
  localparam logic [2:0] PC_EPC    = 3'd3;
  localparam logic [2:0] PC_VECTOR = 3'd4;

endpackage

// File: rtl/hazard_detect.sv
// Load-use comparator: EX load whose destination feeds an operand read in ID.
// Kept standalone so forwarding logic can share the same compare.
module hazard_detect
  import pipeline_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = REG_ADDR_W_DEF
) (
  input  logic [REG_ADDR_W-1:0] i_id_rs,
  input  logic [REG_ADDR_W-1:0] i_id_rt,
  input  logic                  i_id_uses_rs,
  input  logic                  i_id_uses_rt,
  input  logic                  i_ex_mem_read,
  input  logic                  i_ex_reg_write,
  input  logic [REG_ADDR_W-1:0] i_ex_rd,
  output logic                  o_load_use
);

  logic w_rs_hit;
  logic w_rt_hit;

  // $0 is hardwired, so a load targeting it never creates a dependency
  always_comb begin
    w_rs_hit   = i_id_uses_rs && (i_ex_rd == i_id_rs);
    w_rt_hit   = i_id_uses_rt && (i_ex_rd == i_id_rt);
    o_load_use = i_ex_mem_read && i_ex_reg_write && (i_ex_rd != '0) && (w_rs_hit || w_rt_hit);
  end

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Central stall/flush/interrupt sequencer for the 5-stage pipeline registers.
//
// state  | meaning
// RUN    | normal issue; resolves halt > branch > load-use > irq > eret > jump
// DRAIN  | PC held, IF/ID bubbled while older instructions retire before the vector
// VECTOR | one cycle steering PC to the interrupt vector, acknowledging the irq
// HALT   | front end frozen, EX/MEM/WB keep retiring until resume
module pipeline_hazard_controller
  import pipeline_ctrl_pkg::*;
#(
  parameter int DRAIN_CYCLES = 3,
  parameter int REG_ADDR_W   = REG_ADDR_W_DEF
) (
  input  logic                  clock,
  input  logic                  resetN,
  input  logic [REG_ADDR_W-1:0] idRs,
  input  logic [REG_ADDR_W-1:0] idRt,
  input  logic                  idUsesRs,
  input  logic                  idUsesRt,
  input  logic                  idJump,
  input  logic                  idEret,
  input  logic                  exMemRead,
  input  logic                  exRegWrite,
  input  logic [REG_ADDR_W-1:0] exRd,
  input  logic                  exBranchTaken,
  input  logic                  exHalt,
  input  logic                  resume,
  input  logic                  irq,
  input  logic                  intEnable,
  output logic                  pcEnable,
  output logic                  ifidEnable,
  output logic                  idexEnable,
  output logic                  exmemEnable,
  output logic                  memwbEnable,
  output logic                  ifidClear,
  output logic                  idexClear,
  output logic                  exmemClear,
  output logic                  memwbClear,
  output logic [2:0]            pcSelect,
  output logic                  epcLoad,
  output logic                  intAck,
  output logic                  halted
);

  // Counter holds remaining drain cycles minus one, so it is loaded with N-1
  localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES - 1);

  ctrl_state_e r_state;
  ctrl_state_e w_state_nx;
  logic [3:0]  r_cnt;
  logic [3:0]  w_cnt_nx;
  logic        w_load_use;

  hazard_detect #(
    .REG_ADDR_W(REG_ADDR_W)
  ) u_hazard_detect (
    .i_id_rs        (idRs),
    .i_id_rt        (idRt),
    .i_id_uses_rs   (idUsesRs),
    .i_id_uses_rt   (idUsesRt),
    .i_ex_mem_read  (exMemRead),
    .i_ex_reg_write (exRegWrite),
    .i_ex_rd        (exRd),
    .o_load_use     (w_load_use)
  );

  // State and drain counter registers
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      r_state <= ST_RUN;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
    end
  end

  // Next state and per-stage controls; reset forces every stage to clear
  always_comb begin
    w_state_nx  = r_state;
    w_cnt_nx    = r_cnt;
    pcEnable    = 1'b1;
    ifidEnable  = 1'b1;
    idexEnable  = 1'b1;
    exmemEnable = 1'b1;
    memwbEnable = 1'b1;
    ifidClear   = 1'b0;
    idexClear   = 1'b0;
    exmemClear  = 1'b0;
    memwbClear  = 1'b0;
    pcSelect    = PC_SEQ;
    epcLoad     = 1'b0;
    intAck      = 1'b0;
    halted      = 1'b0;

    if (!resetN) begin
      ifidClear  = 1'b1;
      idexClear  = 1'b1;
      exmemClear = 1'b1;
      memwbClear = 1'b1;
      w_state_nx = ST_RUN;
      w_cnt_nx   = '0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (exHalt) begin
            pcEnable   = 1'b0;
            ifidEnable = 1'b0;
            idexClear  = 1'b1;
            w_state_nx = ST_HALT;
          end else if (exBranchTaken) begin
            pcSelect  = PC_BRANCH;
            ifidClear = 1'b1;
            idexClear = 1'b1;
          end else if (w_load_use) begin
            pcEnable   = 1'b0;
            ifidEnable = 1'b0;
            idexClear  = 1'b1;
          end else if (irq && intEnable) begin
            epcLoad    = 1'b1;
            pcEnable   = 1'b0;
            ifidClear  = 1'b1;
            w_cnt_nx   = DRAIN_LOAD;
            w_state_nx = ST_DRAIN;
          end else if (idEret) begin
            pcSelect  = PC_EPC;
            ifidClear = 1'b1;
          end else if (idJump) begin
            pcSelect  = PC_JUMP;
            ifidClear = 1'b1;
          end
        end
        ST_DRAIN: begin
          pcEnable  = 1'b0;
          ifidClear = 1'b1;
          if (exHalt) begin
            // halt wins; pending interrupt is dropped without acknowledge
            ifidEnable = 1'b0;
            idexClear  = 1'b1;
            w_state_nx = ST_HALT;
          end else begin
            if (exBranchTaken) idexClear = 1'b1;
            if (r_cnt == '0) w_state_nx = ST_VECTOR;
            else             w_cnt_nx   = r_cnt - 4'd1;
          end
        end
        ST_VECTOR: begin
          pcSelect   = PC_VECTOR;
          ifidClear  = 1'b1;
          intAck     = 1'b1;
          w_state_nx = ST_RUN;
        end
        ST_HALT: begin
          pcEnable   = 1'b0;
          ifidEnable = 1'b0;
          idexEnable = 1'b0;
          exmemClear = 1'b1;
          halted     = 1'b1;
          if (resume) w_state_nx = ST_RUN;
        end
        default: w_state_nx = ST_RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Randomized and directed checks of the hazard controller against a cycle model.
module tb_pipeline_hazard_controller;

  localparam int D = 3;
  localparam int W = 5;

  logic         clock = 1'b0;
  logic         resetN;
  logic [W-1:0] idRs, idRt, exRd;
  logic         idUsesRs, idUsesRt, idJump, idEret;
  logic         exMemRead, exRegWrite, exBranchTaken, exHalt;
  logic         resume, irq, intEnable;
  logic         pcEnable, ifidEnable, idexEnable, exmemEnable, memwbEnable;
  logic         ifidClear, idexClear, exmemClear, memwbClear;
  logic [2:0]   pcSelect;
  logic         epcLoad, intAck, halted;

  int n_checks = 0;
  int n_errors = 0;

  // model state: frozen flag, pending vector, drain cycles still to run
  bit m_halt = 0, m_vec = 0;
  int m_drain_left = 0;
  bit nx_halt, nx_vec;
  int nx_drain;

  // expected outputs
  bit e_pc, e_ifid, e_idex, e_exmem, e_memwb;
  bit e_ifidc, e_idexc, e_exmemc, e_memwbc;
  int e_sel;
  bit e_epc, e_ack, e_hlt;

  always #5 clock = ~clock;

  pipeline_hazard_controller #(
    .DRAIN_CYCLES(D),
    .REG_ADDR_W  (W)
  ) dut (
    .clock(clock), .resetN(resetN),
    .idRs(idRs), .idRt(idRt), .idUsesRs(idUsesRs), .idUsesRt(idUsesRt),
    .idJump(idJump), .idEret(idEret),
    .exMemRead(exMemRead), .exRegWrite(exRegWrite), .exRd(exRd),
    .exBranchTaken(exBranchTaken), .exHalt(exHalt),
    .resume(resume), .irq(irq), .intEnable(intEnable),
    .pcEnable(pcEnable), .ifidEnable(ifidEnable), .idexEnable(idexEnable),
    .exmemEnable(exmemEnable), .memwbEnable(memwbEnable),
    .ifidClear(ifidClear), .idexClear(idexClear), .exmemClear(exmemClear),
    .memwbClear(memwbClear), .pcSelect(pcSelect),
    .epcLoad(epcLoad), .intAck(intAck), .halted(halted)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic set_idle();
    idRs = '0; idRt = '0; exRd = '0;
    idUsesRs = 0; idUsesRt = 0; idJump = 0; idEret = 0;
    exMemRead = 0; exRegWrite = 0; exBranchTaken = 0; exHalt = 0;
    resume = 0; irq = 0; intEnable = 0;
  endtask

  task automatic model_eval();
    bit lu;
    lu = exMemRead && exRegWrite && (exRd != 0) &&
         ((idUsesRs && exRd == idRs) || (idUsesRt && exRd == idRt));
    {e_pc, e_ifid, e_idex, e_exmem, e_memwb} = 5'b11111;
    {e_ifidc, e_idexc, e_exmemc, e_memwbc} = 4'b0000;
    e_sel = 0; e_epc = 0; e_ack = 0; e_hlt = 0;
    nx_halt = m_halt; nx_vec = m_vec; nx_drain = m_drain_left;
    if (!resetN) begin
      {e_ifidc, e_idexc, e_exmemc, e_memwbc} = 4'b1111;
      nx_halt = 0; nx_vec = 0; nx_drain = 0;
    end else if (m_halt) begin
      e_pc = 0; e_ifid = 0; e_idex = 0; e_exmemc = 1; e_hlt = 1;
      if (resume) nx_halt = 0;
    end else if (m_vec) begin
      e_sel = 4; e_ifidc = 1; e_ack = 1; nx_vec = 0;
    end else if (m_drain_left > 0) begin
      e_pc = 0; e_ifidc = 1;
      if (exHalt) begin
        e_ifid = 0; e_idexc = 1; nx_halt = 1; nx_drain = 0;
      end else begin
        if (exBranchTaken) e_idexc = 1;
        nx_drain = m_drain_left - 1;
        if (nx_drain == 0) nx_vec = 1;
      end
    end else if (exHalt) begin
      e_pc = 0; e_ifid = 0; e_idexc = 1; nx_halt = 1;
    end else if (exBranchTaken) begin
      e_sel = 1; e_ifidc = 1; e_idexc = 1;
    end else if (lu) begin
      e_pc = 0; e_ifid = 0; e_idexc = 1;
    end else if (irq && intEnable) begin
      e_epc = 1; e_pc = 0; e_ifidc = 1; nx_drain = D;
    end else if (idEret) begin
      e_sel = 3; e_ifidc = 1;
    end else if (idJump) begin
      e_sel = 2; e_ifidc = 1;
    end
  endtask

  task automatic check_outputs(input string p);
    check_val({p, ".pcEn"},   pcEnable,    e_pc);
    check_val({p, ".ifidEn"}, ifidEnable,  e_ifid);
    check_val({p, ".idexEn"}, idexEnable,  e_idex);
    check_val({p, ".exmEn"},  exmemEnable, e_exmem);
    check_val({p, ".mwbEn"},  memwbEnable, e_memwb);
    check_val({p, ".ifidCl"}, ifidClear,   e_ifidc);
    check_val({p, ".idexCl"}, idexClear,   e_idexc);
    check_val({p, ".exmCl"},  exmemClear,  e_exmemc);
    check_val({p, ".mwbCl"},  memwbClear,  e_memwbc);
    check_val({p, ".pcSel"},  pcSelect,    e_sel);
    check_val({p, ".epc"},    epcLoad,     e_epc);
    check_val({p, ".ack"},    intAck,      e_ack);
    check_val({p, ".halted"}, halted,      e_hlt);
  endtask

  // called at a falling edge with inputs applied; returns at the next falling edge
  task automatic step(input string p);
    #1;
    model_eval();
    check_outputs(p);
    @(posedge clock);
    m_halt = nx_halt; m_vec = nx_vec; m_drain_left = nx_drain;
    @(negedge clock);
  endtask

  task automatic randomize_inputs();
    idRs = W'($urandom_range(0, 3));
    idRt = W'($urandom_range(0, 3));
    exRd = W'($urandom_range(0, 3));
    idUsesRs      = ($urandom_range(0, 1) == 1);
    idUsesRt      = ($urandom_range(0, 1) == 1);
    exMemRead     = ($urandom_range(0, 2) == 0);
    exRegWrite    = ($urandom_range(0, 3) != 0);
    idJump        = ($urandom_range(0, 4) == 0);
    idEret        = ($urandom_range(0, 4) == 0);
    exBranchTaken = ($urandom_range(0, 5) == 0);
    exHalt        = ($urandom_range(0, 19) == 0);
    resume        = ($urandom_range(0, 3) == 0);
    irq           = ($urandom_range(0, 3) == 0);
    intEnable     = ($urandom_range(0, 1) == 1);
  endtask

  initial begin
    set_idle();
    resetN = 0;
    #2;
    model_eval();
    check_outputs("reset");
    @(negedge clock);
    @(negedge clock);
    resetN = 1;
    step("idle");

    // load-use on $8 stalls exactly one cycle; exRd=0 never stalls
    exMemRead = 1; exRegWrite = 1; exRd = 8; idRs = 8; idUsesRs = 1;
    #1;
    check_val("lu.pcEn", pcEnable, 0);
    check_val("lu.ifidEn", ifidEnable, 0);
    check_val("lu.idexCl", idexClear, 1);
    step("lu");
    set_idle();
    step("lu_after");
    exMemRead = 1; exRegWrite = 1; exRd = 0; idRs = 0; idUsesRs = 1;
    #1;
    check_val("lu0.pcEn", pcEnable, 1);
    step("lu0");

    // branch beats load-use and jump
    set_idle();
    exMemRead = 1; exRegWrite = 1; exRd = 8; idRt = 8; idUsesRt = 1;
    idJump = 1; exBranchTaken = 1;
    #1;
    check_val("br.pcSel", pcSelect, 1);
    check_val("br.pcEn", pcEnable, 1);
    step("br");

    // eret beats jump; both suppressed under load-use
    set_idle();
    idEret = 1; idJump = 1;
    #1;
    check_val("eret.pcSel", pcSelect, 3);
    step("eret");
    exMemRead = 1; exRegWrite = 1; exRd = 5; idRs = 5; idUsesRs = 1;
    #1;
    check_val("eret_lu.pcSel", pcSelect, 0);
    step("eret_lu");

    // interrupt: accept, D drain cycles, one vector cycle, back to RUN
    set_idle();
    irq = 1; intEnable = 1;
    #1;
    check_val("irq.epc", epcLoad, 1);
    step("irq0");
    irq = 0;
    for (int i = 0; i < D; i++) begin
      #1;
      check_val("drain.pcEn", pcEnable, 0);
      step("drain");
    end
    #1;
    check_val("vec.pcSel", pcSelect, 4);
    check_val("vec.ack", intAck, 1);
    step("vec");
    step("post_vec");

    // halt for 10 cycles with irq pending, then resume
    exHalt = 1;
    step("halt0");
    set_idle();
    irq = 1; intEnable = 1;
    for (int i = 0; i < 10; i++) step("halt");
    #1;
    check_val("halt.halted", halted, 1);
    resume = 1; irq = 0;
    step("resume");
    set_idle();
    #1;
    check_val("resume.halted", halted, 0);
    step("after_resume");

    // reset during the first drain cycle aborts without acknowledge
    irq = 1; intEnable = 1;
    step("irq_rst");
    irq = 0;
    #2;
    resetN = 0;
    #1;
    check_val("rst.ifidCl", ifidClear, 1);
    check_val("rst.memwbCl", memwbClear, 1);
    @(negedge clock);
    step("rst_hold");
    resetN = 1;
    for (int i = 0; i < D + 2; i++) begin
      #1;
      check_val("rst_rel.ack", intAck, 0);
      check_val("rst_rel.pcSel", pcSelect, 0);
      step("rst_rel");
    end

    // randomized traffic with occasional resets
    for (int i = 0; i < 600; i++) begin
      randomize_inputs();
      resetN = ($urandom_range(0, 99) != 0);
      step("rand");
    end
    resetN = 1;
    set_idle();
    step("final");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
